ulaplus_palette: RTL and testbench
==================================

Name: ulaplus_palette

Overview:
- Consumer end of the ULAplus palette write path. Holds the 64-entry GRB332 palette written by the CPU-side port decoder through write_req, write_addr and write_data.
- Serves video-side colour lookups, turning an attribute and an ink/paper pixel into 3:3:3 RGB.
- Serves CPU palette readback requests.
- Palette sits in one single-port synchronous RAM, time-multiplexed on clk28 by a small arbiter with a one-entry write buffer and a one-entry read buffer.

Parameters:
- PIPE_OUT_REG, 1, adds the RGB output register stage. 1 gives lookup latency 2; 0 gives latency 1, with outputs driven directly from the RAM read and expansion.

Ports:
- clk28  in  1  system clock
- rst  in  1  synchronous, active-high reset
- write_req  in  1  one-cycle pulse: store write_data at write_addr
- write_addr  in  6  palette index for write
- write_data  in  8  GRB332 colour: G[7:5] R[4:2] B[1:0]
- rd_req  in  1  one-cycle pulse: CPU palette readback request
- rd_addr  in  6  palette index for readback
- rd_data  out  8  readback data, valid while rd_valid=1
- rd_valid  out  1  one-cycle pulse
- pix_stb  in  1  video lookup strobe; never asserted in two consecutive cycles
- pix_attr  in  8  Spectrum attribute byte: FL BR P2..P0 I2..I0
- pix_ink  in  1  1 = ink pixel, 0 = paper pixel
- pix_blank  in  1  border/blank: output black, no RAM access
- r, g, b  out  3 each  expanded colour
- rgb_valid  out  1  pulse, PIPE_OUT_REG+1 cycles after pix_stb

Behaviour:
- Reset: rd_data=0, rd_valid=0, r=g=b=0, rgb_valid=0. Write and read buffers are cleared (pending operations dropped) and the pipeline is flushed. RAM contents are not reset.
- Index:
  - ink = {attr[7:6], 1'b0, attr[2:0]}
  - paper = {attr[7:6], 1'b1, attr[5:3]}
- RAM slot priority each cycle:
  1. video lookup (pix_stb & !pix_blank)
  2. pending write
  3. pending read
- Write buffer:
  - write_req loads the buffer (addr, data, valid). An idle slot in the same cycle commits it directly.
  - A write_req arriving while the buffer is still valid overwrites it; the newer write wins and the older is lost.
  - Because pix_stb is never consecutive, a buffered write commits within 1 cycle.
- Read buffer:
  - rd_req loads the buffer. The read is issued in the first slot free of video and write.
  - rd_valid and rd_data appear the cycle after the RAM read.
  - Coherence: if a write to the same address is pending or committing in the issuing cycle, rd_data returns the written data.
  - Worst-case rd_req to rd_valid is 3 cycles.
- Video lookup:
  - Cycle N: pix_stb, RAM address presented.
  - Cycle N+1: data available.
  - Cycle N+PIPE_OUT_REG+1: r, g, b and rgb_valid pulse.
  - pix_blank=1 with pix_stb: no RAM access; outputs 0 with the same latency, rgb_valid still pulses.
- Expansion:
  - r = d[4:2], g = d[7:5]
  - b = {d[1:0], d[1]|d[0]}
- r, g, b hold their value between strobes; rgb_valid is a pulse only.

Optional Feature:
- Macro: ULAPLUS_READBACK_EN.
- Defined: the read buffer, forwarding and rd_valid behave as specified above.
- Undefined: rd_req is ignored, rd_valid is tied 0 and rd_data is tied 0, and the read buffer logic is removed.

Decomposition:
- Package common gets:
  - typedef ulaplus_idx_t (6 bits)
  - packed struct grb332_t {g[2:0], r[2:0], b[1:0]}
  - function ulaplus_index(attr, ink)
  - function grb_to_rgb9(grb332_t)
- Sub-module: ulaplus_palette_ram, a 64x8 single-port RAM with synchronous read and write-enable. It has no read-during-write forwarding; forwarding lives in the parent.

Test Plan:
- Write 0x1C at addr 5, then pix_stb with attr=0x05, ink=1 -> after 2 cycles rgb_valid=1, r=7, g=0, b=0.
- write_req addr 0x18 data 0xE3 in the same cycle as pix_stb -> video lookup completes unaffected; a later readback of 0x18 returns 0xE3.
- rd_req addr 0x18 in the same cycle as write_req addr 0x18 data 0x42 -> rd_valid within 3 cycles, rd_data=0x42.
- pix_stb with pix_blank=1 and attr=0xFF -> rgb_valid after 2 cycles, r=g=b=0, no RAM access.
- Palette 0x3F=0x03, lookup attr=0xC0, ink=0 (paper index 0x38) vs. 0x3F entry -> b=3'b111 at index 0x3F, and blue expansion 2'b01 -> 3'b011.
- rst asserted one cycle after write_req while the buffer is pending behind pix_stb -> write dropped, outputs 0, rd_valid never pulses; with the macro undefined, rd_req -> rd_valid stays 0.

Source files
------------

// File: rtl/ulaplus_palette_pkg.sv
// ulaplus_palette_pkg
// Shared types and helpers for the ULAplus palette block:
//   ulaplus_idx_t  - 6-bit palette index
//   grb332_t       - packed GRB332 colour as stored in the palette RAM
//   ulaplus_index  - attribute + ink/paper pixel -> palette index
//   grb_to_rgb9    - GRB332 -> 3:3:3 RGB, packed {r, g, b}
package ulaplus_palette_pkg;

  localparam int PAL_DEPTH = 64;
  localparam int GRB_W     = 8;
  localparam int RGB_W     = 9;

  typedef logic [5:0] ulaplus_idx_t;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [1:0] b;
  } grb332_t;

  // Ink entries live in the lower half of each CLUT, paper in the upper half.
  function automatic ulaplus_idx_t ulaplus_index(input logic [7:0] attr, input logic ink);
    return ink ? {attr[7:6], 1'b0, attr[2:0]} : {attr[7:6], 1'b1, attr[5:3]};
  endfunction

  // Blue has only two stored bits; the LSB is their OR so that any non-zero
  // blue stretches towards full scale.
  function automatic logic [RGB_W-1:0] grb_to_rgb9(input grb332_t c);
    return {c.r, c.g, c.b, c.b[1] | c.b[0]};
  endfunction

endpackage

// File: rtl/ulaplus_palette_ram.sv
// ulaplus_palette_ram
// 64x8 single-port RAM, synchronous write and synchronous read.
// A read in the same cycle as a write returns the old contents; any
// forwarding is the parent's responsibility.
// Ports:
//   clk28    - clock
//   i_we     - write enable
//   i_addr   - palette index (read and write)
//   i_wdata  - write data (GRB332)
//   o_rdata  - read data, valid the cycle after i_addr is presented
module ulaplus_palette_ram
  import ulaplus_palette_pkg::*;
(
  input  logic             clk28,
  input  logic             i_we,
  input  ulaplus_idx_t     i_addr,
  input  logic [GRB_W-1:0] i_wdata,
  output logic [GRB_W-1:0] o_rdata
);

  logic [GRB_W-1:0] r_mem [PAL_DEPTH];
  logic [GRB_W-1:0] r_rdata;

  always_ff @(posedge clk28) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ulaplus_palette.sv
// ulaplus_palette
// 64-entry ULAplus GRB332 palette in one single-port RAM, shared between
// video lookups (highest priority), buffered CPU writes and buffered CPU
// readbacks.
// Optional feature macro: ULAPLUS_READBACK_EN (CPU readback path; when
// undefined rd_req is ignored and rd_valid/rd_data are tied to 0).
// Parameter:
//   PIPE_OUT_REG - 1: RGB output register, lookup latency 2; 0: latency 1
// Ports:
//   clk28, rst                        - clock, synchronous active-high reset
//   write_req, write_addr, write_data - palette write (GRB332)
//   rd_req, rd_addr, rd_data, rd_valid - CPU palette readback
//   pix_stb, pix_attr, pix_ink, pix_blank - video lookup request
//   r, g, b, rgb_valid                - expanded colour, valid pulse
module ulaplus_palette
  import ulaplus_palette_pkg::*;
#(
  parameter int PIPE_OUT_REG = 1
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic             write_req,
  input  ulaplus_idx_t     write_addr,
  input  logic [GRB_W-1:0] write_data,
  input  logic             rd_req,
  input  ulaplus_idx_t     rd_addr,
  output logic [GRB_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             pix_stb,
  input  logic [7:0]       pix_attr,
  input  logic             pix_ink,
  input  logic             pix_blank,
  output logic [2:0]       r,
  output logic [2:0]       g,
  output logic [2:0]       b,
  output logic             rgb_valid
);

  logic             w_vid;
  ulaplus_idx_t     w_pix_idx;
  ulaplus_idx_t     w_ram_addr;
  ulaplus_idx_t     w_rd_addr;
  logic [GRB_W-1:0] w_ram_q;

  assign w_vid     = pix_stb & ~pix_blank;
  assign w_pix_idx = ulaplus_index(pix_attr, pix_ink);

  // Write buffer: the newest request always wins; a write committing in
  // the reset cycle is dropped along with the buffer.
  logic             r_wb_vld;
  ulaplus_idx_t     r_wb_addr;
  logic [GRB_W-1:0] r_wb_data;
  logic             w_wr_pend;
  logic             w_wr_commit;
  ulaplus_idx_t     w_wr_addr;
  logic [GRB_W-1:0] w_wr_data;

  assign w_wr_pend   = (write_req | r_wb_vld) & ~rst;
  assign w_wr_addr   = write_req ? write_addr : r_wb_addr;
  assign w_wr_data   = write_req ? write_data : r_wb_data;
  assign w_wr_commit = w_wr_pend & ~w_vid;

  always_ff @(posedge clk28) begin
    if (rst) r_wb_vld <= 1'b0;
    else     r_wb_vld <= w_wr_pend & w_vid;
  end

  always_ff @(posedge clk28) begin
    if (write_req) begin
      r_wb_addr <= write_addr;
      r_wb_data <= write_data;
    end
  end

`ifdef ULAPLUS_READBACK_EN
  // Read buffer. A read may share a cycle with a committing write only when
  // both target the same index: the write data is then forwarded and the
  // RAM result ignored.
  logic             r_rb_vld;
  ulaplus_idx_t     r_rb_addr;
  logic             w_rd_pend;
  logic             w_rd_fwd;
  logic             w_rd_issue;
  logic             r_rd_vld_p1;
  logic             r_rd_fwd_p1;
  logic [GRB_W-1:0] r_rd_fwd_data_p1;

  assign w_rd_pend  = (rd_req | r_rb_vld) & ~rst;
  assign w_rd_addr  = rd_req ? rd_addr : r_rb_addr;
  assign w_rd_fwd   = w_wr_pend & (w_wr_addr == w_rd_addr);
  assign w_rd_issue = w_rd_pend & ~w_vid & (~w_wr_pend | w_rd_fwd);

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_rb_vld    <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rb_vld    <= w_rd_pend & ~w_rd_issue;
      r_rd_vld_p1 <= w_rd_issue;
    end
  end

  always_ff @(posedge clk28) begin
    if (rd_req) r_rb_addr <= rd_addr;
    r_rd_fwd_p1      <= w_rd_fwd;
    r_rd_fwd_data_p1 <= w_wr_data;
  end

  // ---- stage p1: readback data from RAM or forwarded write ----
  assign rd_valid = r_rd_vld_p1;
  assign rd_data  = !r_rd_vld_p1 ? '0 : (r_rd_fwd_p1 ? r_rd_fwd_data_p1 : w_ram_q);
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_req, rd_addr};
  assign w_rd_addr   = '0;
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
`endif

  assign w_ram_addr = w_vid ? w_pix_idx : (w_wr_commit ? w_wr_addr : w_rd_addr);

  ulaplus_palette_ram u_ram (
    .clk28   (clk28),
    .i_we    (w_wr_commit),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wr_data),
    .o_rdata (w_ram_q)
  );

  // ---- stage p1: RAM data available, colour expansion ----
  logic             r_pix_vld_p1;
  logic             r_pix_blank_p1;
  logic [RGB_W-1:0] w_rgb_p1;
  logic [RGB_W-1:0] r_rgb_hold;
  logic [RGB_W-1:0] w_rgb_out;

  always_ff @(posedge clk28) begin
    if (rst) r_pix_vld_p1 <= 1'b0;
    else     r_pix_vld_p1 <= pix_stb;
  end

  always_ff @(posedge clk28) begin
    r_pix_blank_p1 <= pix_blank;
  end

  assign w_rgb_p1 = r_pix_blank_p1 ? '0 : grb_to_rgb9(grb332_t'(w_ram_q));

  // Colour output holds its last value between strobes.
  always_ff @(posedge clk28) begin
    if (rst)               r_rgb_hold <= '0;
    else if (r_pix_vld_p1) r_rgb_hold <= w_rgb_p1;
  end

  // ---- stage p2: optional output register ----
  generate
    if (PIPE_OUT_REG != 0) begin : g_out_reg
      logic r_pix_vld_p2;
      always_ff @(posedge clk28) begin
        if (rst) r_pix_vld_p2 <= 1'b0;
        else     r_pix_vld_p2 <= r_pix_vld_p1;
      end
      assign w_rgb_out = r_rgb_hold;
      assign rgb_valid = r_pix_vld_p2;
    end else begin : g_out_comb
      assign w_rgb_out = r_pix_vld_p1 ? w_rgb_p1 : r_rgb_hold;
      assign rgb_valid = r_pix_vld_p1;
    end
  endgenerate

  assign {r, g, b} = w_rgb_out;

endmodule

// File: tb/tb_ulaplus_palette.sv
// tb_ulaplus_palette
// Self-checking bench for ulaplus_palette (PIPE_OUT_REG=1). The reference
// model keeps the palette as a plain array plus a single pending write and a
// short list of in-flight lookup results. Readback scenarios are exercised
// when ULAPLUS_READBACK_EN is defined; otherwise rd_valid/rd_data must stay 0.
module tb_ulaplus_palette;

  logic       clk28 = 1'b0;
  logic       rst = 1'b0;
  logic       write_req = 1'b0;
  logic [5:0] write_addr = '0;
  logic [7:0] write_data = '0;
  logic       rd_req = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       pix_stb = 1'b0;
  logic [7:0] pix_attr = '0;
  logic       pix_ink = 1'b0;
  logic       pix_blank = 1'b0;
  logic [2:0] r, g, b;
  logic       rgb_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ulaplus_palette #(.PIPE_OUT_REG(1)) dut (
    .clk28(clk28), .rst(rst),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .pix_stb(pix_stb), .pix_attr(pix_attr), .pix_ink(pix_ink), .pix_blank(pix_blank),
    .r(r), .g(g), .b(b), .rgb_valid(rgb_valid)
  );

  always #5 clk28 = ~clk28;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int unsigned pal [64];
  bit          pend_vld = 0;
  int unsigned pend_addr, pend_data;
  bit          s1_vld = 0, s2_vld = 0;
  int unsigned s1_rgb, s2_rgb;
  bit          exp_vld = 0;
  int unsigned exp_rgb = 0;

  function automatic int unsigned m_idx(int unsigned attr, bit ink);
    int unsigned clut = attr / 64;
    if (ink) return clut * 16 + (attr % 8);
    else     return clut * 16 + 8 + ((attr / 8) % 8);
  endfunction

  // Returns {r,g,b} as r*64 + g*8 + b.
  function automatic int unsigned m_rgb(int unsigned d);
    int unsigned rr = (d / 4) % 8;
    int unsigned gg = d / 32;
    int unsigned b2 = d % 4;
    int unsigned bb = b2 * 2 + ((b2 != 0) ? 1 : 0);
    return rr * 64 + gg * 8 + bb;
  endfunction

  // Advance the model by one clock edge with the currently driven inputs,
  // let the DUT take the edge, then release the one-cycle pulses.
  task automatic step();
    int unsigned res;
    if (rst) begin
      pend_vld = 0; s1_vld = 0; s2_vld = 0; exp_rgb = 0;
    end else begin
      res = pix_blank ? 0 : m_rgb(pal[m_idx(pix_attr, pix_ink)]);
      s2_vld = s1_vld; s2_rgb = s1_rgb;
      s1_vld = pix_stb; s1_rgb = res;
      if (pix_stb && !pix_blank) begin
        if (write_req) begin
          pend_vld = 1; pend_addr = write_addr; pend_data = write_data;
        end
      end else begin
        if (write_req)     pal[write_addr] = write_data;
        else if (pend_vld) pal[pend_addr] = pend_data;
        pend_vld = 0;
      end
      if (s2_vld) exp_rgb = s2_rgb;
    end
    exp_vld = s2_vld;
    @(posedge clk28); #1;
    rst = 0; write_req = 0; rd_req = 0; pix_stb = 0; pix_blank = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; step();
    rst = 1; step();
    n_cmp++; if (rgb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rgb_valid: got %b want 0", rgb_valid); end
    n_cmp++; if ({r, g, b} !== 9'd0) begin n_bad++; $display("FAIL reset_rgb: got %h want 000", {r, g, b}); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
  endtask

  task automatic fill_palette();
    for (int i = 0; i < 64; i++) begin
      write_req = 1; write_addr = 6'(i); write_data = 8'($urandom);
      step();
    end
    n_cmp++; if (rgb_valid !== 1'b0) begin n_bad++; $display("FAIL fill_rgb_valid: got %b want 0", rgb_valid); end
  endtask

  task automatic test_basic_lookup();
    write_req = 1; write_addr = 6'd5; write_data = 8'h1C; step();
    pix_stb = 1; pix_attr = 8'h05; pix_ink = 1; step();
    n_cmp++; if (rgb_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", rgb_valid); end
    step();
    n_cmp++; if (rgb_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", rgb_valid); end
    n_cmp++; if ({r, g, b} !== {3'd7, 3'd0, 3'd0}) begin n_bad++; $display("FAIL basic_rgb: got r=%0d g=%0d b=%0d want r=7 g=0 b=0", r, g, b); end
    step();
    n_cmp++; if (rgb_valid !== 1'b0 || {r, g, b} !== {3'd7, 3'd0, 3'd0}) begin n_bad++; $display("FAIL basic_hold: got v=%b rgb=%h want v=0 rgb=1c0", rgb_valid, {r, g, b}); end
  endtask

  task automatic test_write_during_pix();
    pix_stb = 1; pix_attr = 8'h05; pix_ink = 1;
    write_req = 1; write_addr = 6'h18; write_data = 8'hE3; step();
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== {3'd7, 3'd0, 3'd0}) begin n_bad++; $display("FAIL wpix_lookup: got v=%b rgb=%h want v=1 rgb=1c0", rgb_valid, {r, g, b}); end
    pix_stb = 1; pix_attr = 8'h40; pix_ink = 0; step();
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== {3'd0, 3'd7, 3'd7}) begin n_bad++; $display("FAIL wpix_entry18: got v=%b rgb=%h want v=1 rgb=03f", rgb_valid, {r, g, b}); end
`ifdef ULAPLUS_READBACK_EN
    begin
      bit seen = 0;
      rd_req = 1; rd_addr = 6'h18;
      for (int k = 0; k < 3 && !seen; k++) begin
        step();
        if (rd_valid === 1'b1) begin
          seen = 1;
          n_cmp++; if (rd_data !== 8'hE3) begin n_bad++; $display("FAIL wpix_readback: got %h want e3", rd_data); end
        end
      end
      if (!seen) begin n_cmp++; n_bad++; $display("FAIL wpix_readback_timeout: got no rd_valid want pulse within 3"); end
    end
`endif
  endtask

  task automatic test_readback();
`ifdef ULAPLUS_READBACK_EN
    // Same-cycle write and read of one address: written data comes back.
    for (int v = 0; v < 2; v++) begin
      bit seen = 0;
      bit [7:0] wd = (v == 0) ? 8'h42 : 8'h9B;
      write_req = 1; write_addr = 6'h18; write_data = wd;
      rd_req = 1; rd_addr = 6'h18;
      if (v == 1) begin pix_stb = 1; pix_attr = 8'h12; pix_ink = 1; end
      for (int k = 0; k < 3 && !seen; k++) begin
        step();
        if (rd_valid === 1'b1) begin
          seen = 1;
          n_cmp++; if (rd_data !== wd) begin n_bad++; $display("FAIL rd_forward%0d: got %h want %h", v, rd_data, wd); end
        end
      end
      if (!seen) begin n_cmp++; n_bad++; $display("FAIL rd_forward_timeout%0d: got no rd_valid want pulse within 3", v); end
      step(); step();
    end
    // Plain readback of random entries.
    for (int t = 0; t < 8; t++) begin
      bit seen = 0;
      int unsigned a = $urandom_range(63);
      rd_req = 1; rd_addr = 6'(a);
      for (int k = 0; k < 3 && !seen; k++) begin
        step();
        if (rd_valid === 1'b1) begin
          seen = 1;
          n_cmp++; if (rd_data !== 8'(pal[a])) begin n_bad++; $display("FAIL rd_entry_%0d: got %h want %h", a, rd_data, 8'(pal[a])); end
        end
      end
      if (!seen) begin n_cmp++; n_bad++; $display("FAIL rd_timeout_%0d: got no rd_valid want pulse within 3", a); end
      step();
    end
`else
    rd_req = 1; rd_addr = 6'h18;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin n_bad++; $display("FAIL rd_disabled: got v=%b d=%h want v=0 d=00", rd_valid, rd_data); end
    end
`endif
  endtask

  task automatic test_blank();
    pix_stb = 1; pix_blank = 1; pix_attr = 8'hFF; pix_ink = 1; step();
    n_cmp++; if (rgb_valid !== 1'b0) begin n_bad++; $display("FAIL blank_early_valid: got %b want 0", rgb_valid); end
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== 9'd0) begin n_bad++; $display("FAIL blank_rgb: got v=%b rgb=%h want v=1 rgb=000", rgb_valid, {r, g, b}); end
  endtask

  task automatic test_blue_expand();
    write_req = 1; write_addr = 6'h3F; write_data = 8'h03; step();
    write_req = 1; write_addr = 6'h38; write_data = 8'h01; step();
    pix_stb = 1; pix_attr = 8'hF8; pix_ink = 0; step();
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== {3'd0, 3'd0, 3'b111}) begin n_bad++; $display("FAIL blue_3f: got v=%b rgb=%h want v=1 rgb=007", rgb_valid, {r, g, b}); end
    pix_stb = 1; pix_attr = 8'hC0; pix_ink = 0; step();
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== {3'd0, 3'd0, 3'b011}) begin n_bad++; $display("FAIL blue_38: got v=%b rgb=%h want v=1 rgb=003", rgb_valid, {r, g, b}); end
  endtask

  task automatic test_reset_drop();
    write_req = 1; write_addr = 6'h2A; write_data = 8'h5A; step();
    pix_stb = 1; pix_attr = 8'h05; pix_ink = 1;
    write_req = 1; write_addr = 6'h2A; write_data = 8'hA5;
    rd_req = 1; rd_addr = 6'h2A; step();
    rst = 1; step();
    n_cmp++; if (rgb_valid !== 1'b0 || {r, g, b} !== 9'd0) begin n_bad++; $display("FAIL rstdrop_out: got v=%b rgb=%h want v=0 rgb=000", rgb_valid, {r, g, b}); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rd_valid !== 1'b0 || rgb_valid !== 1'b0) begin n_bad++; $display("FAIL rstdrop_quiet: got rd_valid=%b rgb_valid=%b want 0 0", rd_valid, rgb_valid); end
      step();
    end
    pix_stb = 1; pix_attr = 8'h90; pix_ink = 0; step();
    step();
    n_cmp++; if (rgb_valid !== 1'b1 || {r, g, b} !== {3'd6, 3'd2, 3'b101}) begin n_bad++; $display("FAIL rstdrop_entry: got v=%b rgb=%h want v=1 rgb=195", rgb_valid, {r, g, b}); end
  endtask

  task automatic test_random();
    bit prev = 0;
    for (int c = 0; c < 400; c++) begin
      if (!prev && ($urandom_range(99) < 55)) begin
        pix_stb = 1; pix_attr = 8'($urandom); pix_ink = 1'($urandom);
        pix_blank = ($urandom_range(7) == 0);
      end
      if ($urandom_range(2) == 0) begin
        write_req = 1; write_addr = 6'($urandom); write_data = 8'($urandom);
      end
      prev = pix_stb;
      step();
      n_cmp++; if (rgb_valid !== exp_vld) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, rgb_valid, exp_vld); end
      n_cmp++; if ({r, g, b} !== 9'(exp_rgb)) begin n_bad++; $display("FAIL rand_rgb c%0d: got %h want %h", c, {r, g, b}, 9'(exp_rgb)); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rand_rd_valid c%0d: got %b want 0", c, rd_valid); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    fill_palette();
    test_basic_lookup();
    test_write_during_pix();
    test_readback();
    test_blank();
    test_blue_expand();
    test_reset_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
